gray_seq_ctrl: RTL and testbench

- Sequencer for the team's 4-bit `grayenc` code converter.
- Owns a 4-bit binary position counter and steps it up or down, one step every DWELL cycles, until a programmable limit is reached.
- Drives the counter into an internal `grayenc` instance and registers the converted code.
- Sits between front-panel controls (start/stop/step/load) and display/actuator logic that consumes the code.

---
 rtl/gray_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_gray_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_ctrl.sv
// Up/down position sequencer driving a 4-bit grayenc converter with dwell timing and a limit stop.
// Optional macro GRAY_SEQ_PARITY_EN adds a registered code_par output (XOR of code bits).

module grayenc (
   input  logic [3:0] bin,
   output logic [3:0] code
);
   logic [3:0] idx;

   // Position 0 maps to the last Gray code so that position 1 yields 0000.
   assign idx  = bin - 4'd1;
   assign code = idx ^ (idx >> 1);
endmodule

module gray_seq_ctrl #(
   parameter int DWELL = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       step,
   input  logic       dir,
   input  logic [3:0] limit,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] bin,
   output logic [3:0] code,
   output logic       code_valid,
   output logic       wrap,
   output logic       busy,
   output logic       done
`ifdef GRAY_SEQ_PARITY_EN
   ,
   output logic       code_par
`endif
);
   localparam int DW_W = $clog2(DWELL + 1);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      bin_q, bin_d;
   logic [3:0]      code_q, code_d;
   logic            code_valid_q, code_valid_d;
   logic            wrap_q, wrap_d;
   logic [DW_W-1:0] dwell_q, dwell_d;
   logic [3:0]      bin_adv;
   logic            wrap_adv;
   logic            advance;

   always_comb begin
      bin_adv  = dir ? bin_q + 4'd1 : bin_q - 4'd1;
      wrap_adv = dir ? (bin_q == 4'hF) : (bin_q == 4'h0);
   end

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      bin_d        = bin_q;
      code_valid_d = 1'b0;
      wrap_d       = 1'b0;
      dwell_d      = dwell_q;
      advance      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               bin_d        = load_val;
               code_valid_d = 1'b1;
            end else if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_RUN;
               dwell_d = '0;
            end else if (step) begin
               advance = 1'b1;
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (dwell_q == DWELL_LAST) begin
               advance = 1'b1;
               dwell_d = '0;
               // Limit is only compared against the post-advance position.
               if (bin_adv == limit) state_d = ST_DONE;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end

         ST_DONE: begin
            if (load) begin
               bin_d        = load_val;
               code_valid_d = 1'b1;
               state_d      = ST_IDLE;
            end else if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d = ST_RUN;
               dwell_d = '0;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (advance) begin
         bin_d        = bin_adv;
         code_valid_d = 1'b1;
         wrap_d       = wrap_adv;
      end
   end

   grayenc u_grayenc (
      .bin  (bin_d),
      .code (code_d)
   );

   // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         bin_q        <= 4'b0000;
         code_q       <= 4'b1000;
         code_valid_q <= 1'b0;
         wrap_q       <= 1'b0;
         dwell_q      <= '0;
      end else begin
         state_q      <= state_d;
         bin_q        <= bin_d;
         code_q       <= code_d;
         code_valid_q <= code_valid_d;
         wrap_q       <= wrap_d;
         dwell_q      <= dwell_d;
      end
   end

`ifdef GRAY_SEQ_PARITY_EN
   logic code_par_q, code_par_d;

   assign code_par_d = ^code_d;

   always_ff @(posedge clk) begin
      if (reset) code_par_q <= 1'b1;
      else       code_par_q <= code_par_d;
   end

   assign code_par = code_par_q;
`endif

   assign bin        = bin_q;
   assign code       = code_q;
   assign code_valid = code_valid_q;
   assign wrap       = wrap_q;
   assign busy       = (state_q == ST_RUN);
   assign done       = (state_q == ST_DONE);
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl: DWELL=1 and DWELL=3 instances share stimulus,
// checked by vector tables, directed sequences and a randomized behavioural model.

module tb_gray_seq_ctrl;
   logic       clk = 1'b0;
   logic       reset, start, stop, step, dir, load;
   logic [3:0] limit, load_val;

   logic [3:0] bin1, code1, bin3, code3;
   logic       cv1, wrap1, busy1, done1;
   logic       cv3, wrap3, busy3, done3;
`ifdef GRAY_SEQ_PARITY_EN
   logic       par1, par3;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gray_seq_ctrl #(.DWELL(1)) dut1 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step), .dir(dir),
      .limit(limit), .load(load), .load_val(load_val),
      .bin(bin1), .code(code1), .code_valid(cv1), .wrap(wrap1), .busy(busy1), .done(done1)
`ifdef GRAY_SEQ_PARITY_EN
      , .code_par(par1)
`endif
   );

   gray_seq_ctrl #(.DWELL(3)) dut3 (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .step(step), .dir(dir),
      .limit(limit), .load(load), .load_val(load_val),
      .bin(bin3), .code(code3), .code_valid(cv3), .wrap(wrap3), .busy(busy3), .done(done3)
`ifdef GRAY_SEQ_PARITY_EN
      , .code_par(par3)
`endif
   );

   // Expected converter output for each binary position, listed from the code sequence.
   int gray_tab[16] = '{8, 0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9};

   // Reference model: 0 = idle, 1 = running, 2 = done; one entry per instance.
   int m_dwell[2] = '{1, 3};
   int m_st[2], m_bin[2], m_cv[2], m_wr[2], m_dw[2];

   task automatic model_update();
      for (int i = 0; i < 2; i++) begin
         bit adv = 0;
         if (reset) begin
            m_st[i] = 0; m_bin[i] = 0; m_cv[i] = 0; m_wr[i] = 0; m_dw[i] = 0;
            continue;
         end
         m_cv[i] = 0;
         m_wr[i] = 0;
         if (m_st[i] == 0) begin
            if (load)       begin m_bin[i] = int'(load_val); m_cv[i] = 1; end
            else if (stop)  ;
            else if (start) begin m_st[i] = 1; m_dw[i] = 0; end
            else if (step)  adv = 1;
         end else if (m_st[i] == 1) begin
            if (stop) m_st[i] = 0;
            else if (m_dw[i] == m_dwell[i] - 1) begin adv = 1; m_dw[i] = 0; end
            else m_dw[i]++;
         end else begin
            if (load)       begin m_bin[i] = int'(load_val); m_cv[i] = 1; m_st[i] = 0; end
            else if (stop)  m_st[i] = 0;
            else if (start) begin m_st[i] = 1; m_dw[i] = 0; end
         end
         if (adv) begin
            m_wr[i]  = (dir && m_bin[i] == 15) || (!dir && m_bin[i] == 0) ? 1 : 0;
            m_bin[i] = (m_bin[i] + (dir ? 1 : 15)) % 16;
            m_cv[i]  = 1;
            if (m_st[i] == 1 && m_bin[i] == int'(limit)) m_st[i] = 2;
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle_inputs();
      reset = 0; start = 0; stop = 0; step = 0; load = 0;
   endtask

   function automatic logic [11:0] model_pack(input int i);
      return {4'(m_bin[i]), 4'(gray_tab[m_bin[i]]), m_cv[i] == 1, m_wr[i] == 1,
              m_st[i] == 1, m_st[i] == 2};
   endfunction

   typedef struct {
      logic       start, stop, step, load, dir;
      logic [3:0] limit, load_val;
      logic [3:0] e_bin, e_code;
      logic       e_cv, e_wrap, e_busy, e_done;
   } vec_t;

   function automatic vec_t mk(input logic st, sp, sx, ld, dr, input logic [3:0] lim, lv,
                               input logic [3:0] eb, ec, input logic ecv, ew, ebz, edn);
      vec_t v;
      v.start = st; v.stop = sp; v.step = sx; v.load = ld; v.dir = dr;
      v.limit = lim; v.load_val = lv;
      v.e_bin = eb; v.e_code = ec; v.e_cv = ecv; v.e_wrap = ew; v.e_busy = ebz; v.e_done = edn;
      return v;
   endfunction

   initial begin
      vec_t vecs[$];
      int   adv_cnt, wrap_cnt, cyc;

      // Manual steps, down-wrap run to limit 8, step ignored in DONE, load beats start.
      vecs.push_back(mk(0,0,1,0,1, 0,0, 4'd1,  4'b0000, 1,0,0,0));
      vecs.push_back(mk(0,0,1,0,1, 0,0, 4'd2,  4'b0001, 1,0,0,0));
      vecs.push_back(mk(0,0,1,0,1, 0,0, 4'd3,  4'b0011, 1,0,0,0));
      vecs.push_back(mk(0,0,1,0,1, 0,0, 4'd4,  4'b0010, 1,0,0,0));
      vecs.push_back(mk(0,0,0,1,1, 0,1, 4'd1,  4'b0000, 1,0,0,0));
      vecs.push_back(mk(1,0,0,0,0, 8,0, 4'd1,  4'b0000, 0,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd0,  4'b1000, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd15, 4'b1001, 1,1,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd14, 4'b1011, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd13, 4'b1010, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd12, 4'b1110, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd11, 4'b1111, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd10, 4'b1101, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd9,  4'b1100, 1,0,1,0));
      vecs.push_back(mk(0,0,0,0,0, 8,0, 4'd8,  4'b0100, 1,0,0,1));
      vecs.push_back(mk(0,0,1,0,0, 8,0, 4'd8,  4'b0100, 0,0,0,1));
      vecs.push_back(mk(1,0,0,1,0, 8,5, 4'd5,  4'b0110, 1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0, 8,5, 4'd5,  4'b0110, 0,0,0,0));

      for (int i = 0; i < 16; i++) begin
         m_st[i % 2] = 0; m_bin[i % 2] = 0; m_cv[i % 2] = 0; m_wr[i % 2] = 0; m_dw[i % 2] = 0;
      end

      // Reset held for two cycles, then released.
      idle_inputs(); reset = 1; dir = 1; limit = 0; load_val = 0;
      tick(); tick();
      reset = 0;
      tick();
      check("reset_bin",  bin1,  4'b0000);
      check("reset_code", code1, 4'b1000);
      check("reset_flags", {cv1, wrap1, busy1, done1}, 4'b0000);
      check("reset_dut3", {bin3, code3, cv3, busy3, done3}, {4'b0000, 4'b1000, 3'b000});
`ifdef GRAY_SEQ_PARITY_EN
      check("reset_par", par1, 1'b1);
`endif

      foreach (vecs[k]) begin
         start = vecs[k].start; stop = vecs[k].stop; step = vecs[k].step; load = vecs[k].load;
         dir = vecs[k].dir; limit = vecs[k].limit; load_val = vecs[k].load_val;
         tick();
         check($sformatf("vec%0d", k), {bin1, code1, cv1, wrap1, busy1, done1},
               {vecs[k].e_bin, vecs[k].e_code, vecs[k].e_cv, vecs[k].e_wrap,
                vecs[k].e_busy, vecs[k].e_done});
      end
      idle_inputs();

      // Dwell timing on the DWELL=3 instance: advance only at E0+3, stop at E0+4.
      reset = 1; tick(); reset = 0;
      load = 1; load_val = 4'd1; dir = 1; limit = 4'd9; tick(); load = 0;
      start = 1; tick(); start = 0;
      check("dwell_e0", {bin3, busy3}, {4'd1, 1'b1});
      tick(); check("dwell_e1", {bin3, cv3}, {4'd1, 1'b0});
      tick(); check("dwell_e2", {bin3, cv3}, {4'd1, 1'b0});
      tick(); check("dwell_e3", {bin3, code3, cv3}, {4'd2, 4'b0001, 1'b1});
      stop = 1; tick(); stop = 0;
      check("dwell_stop", {bin3, cv3, busy3, done3}, {4'd2, 3'b000});
      for (int i = 0; i < 4; i++) begin
         tick();
         check("dwell_hold", {bin3, cv3, busy3}, {4'd2, 2'b00});
      end

      // Full-cycle run from bin == limit on the DWELL=1 instance.
      load = 1; load_val = 4'd15; tick(); load = 0;
      check("full_load", {bin1, code1}, {4'd15, 4'b1001});
      dir = 1; limit = 4'd15; start = 1; tick(); start = 0;
      adv_cnt = 0; wrap_cnt = 0; cyc = 0;
      while (!done1 && cyc < 40) begin
         tick();
         cyc++;
         adv_cnt  += int'(cv1);
         wrap_cnt += int'(wrap1);
      end
      check("full_done", {done1, busy1}, 2'b10);
      check("full_advances", adv_cnt, 16);
      check("full_wraps", wrap_cnt, 1);
      check("full_bin", {bin1, code1}, {4'd15, 4'b1001});

      // Reset asserted mid-run.
      dir = 0; limit = 4'd3; start = 1; tick(); start = 0;
      tick(); tick();
      reset = 1; tick(); reset = 0;
      check("midrun_reset", {bin1, code1, cv1, wrap1, busy1, done1}, {4'b0000, 4'b1000, 4'b0000});
      check("midrun_reset3", {bin3, code3, busy3}, {4'b0000, 4'b1000, 1'b0});
      tick();
      check("midrun_idle", {bin1, busy1, done1}, {4'b0000, 2'b00});

      // Randomized traffic against the model, both instances.
      for (int n = 0; n < 3000; n++) begin
         reset    = ($urandom % 200) == 0;
         load     = ($urandom % 16) == 0;
         stop     = ($urandom % 12) == 0;
         start    = ($urandom % 6) == 0;
         step     = ($urandom % 4) == 0;
         dir      = 1'($urandom);
         if (($urandom % 8) == 0) limit = 4'($urandom);
         load_val = 4'($urandom);
         tick();
         check("rand_d1", {bin1, code1, cv1, wrap1, busy1, done1}, model_pack(0));
         check("rand_d3", {bin3, code3, cv3, wrap3, busy3, done3}, model_pack(1));
`ifdef GRAY_SEQ_PARITY_EN
         check("rand_par1", par1, ^4'(gray_tab[m_bin[0]]));
         check("rand_par3", par3, ^4'(gray_tab[m_bin[1]]));
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
      $fatal(1, "watchdog expired");
   end
endmodule
